// File: rtl/hwpe_tcdm_responder_if.sv
// TCDM request/response bundle between an HWPE streamer port (master)
// and a memory-side responder (slave).
interface hwpe_tcdm_responder_if;
   logic        req;
   logic        gnt;
   logic [31:0] add;
   logic        wen;     // 1 = read, 0 = write
   logic [3:0]  be;
   logic [31:0] data;
   logic [31:0] r_data;
   logic        r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );
endinterface

// File: rtl/hwpe_tcdm_responder.sv
// TCDM slave responder: grants requests, merges byte-enabled writes into a
// word-addressed memory and returns read data after a fixed latency.
module hwpe_tcdm_responder #(
   parameter int unsigned MEM_WORDS       = 1024,
   parameter int unsigned LATENCY         = 1,
   parameter logic [31:0] BASE_ADDR       = 32'h0,
   parameter bit          RVALID_ON_WRITE = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 stall_i,
   hwpe_tcdm_responder_if.slave tcdm,
   output logic [31:0]          nb_reads_o,
   output logic [31:0]          nb_writes_o
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);

   logic [31:0]             offset;
   logic [IDX_W-1:0]        idx;
   logic                    rd_en;
   logic                    wr_en;
   logic [31:0]             mem_q [MEM_WORDS];

   logic [LATENCY-1:0]       valid_d, valid_q;
   logic [LATENCY-1:0][31:0] data_d, data_q;

   logic [31:0]             nb_reads_d, nb_reads_q;
   logic [31:0]             nb_writes_d, nb_writes_q;

   // Out-of-window addresses alias through the 32-bit wrap and the index truncation.
   assign offset = tcdm.add - BASE_ADDR;
   assign idx    = offset[IDX_W+1:2];

   assign tcdm.gnt = tcdm.req & ~stall_i & ~clear_i;
   assign rd_en    = tcdm.gnt & tcdm.wen;
   assign wr_en    = tcdm.gnt & ~tcdm.wen;

   // Byte-merged write into storage; memory is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (tcdm.be[k]) begin
               mem_q[idx][8*k +: 8] <= tcdm.data[8*k +: 8];
            end
         end
      end
   end

   // Response pipeline next state; invalid stages always carry zero data.
   always_comb begin
      valid_d = '0;
      data_d  = '0;
      if (!clear_i) begin
         valid_d[0] = rd_en | (wr_en & RVALID_ON_WRITE);
         data_d[0]  = rd_en ? mem_q[idx] : 32'h0;
         for (int i = 1; i < int'(LATENCY); i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
      end
   end

   // Response pipeline registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign tcdm.r_valid = valid_q[LATENCY-1];
   assign tcdm.r_data  = data_q[LATENCY-1];

   // Saturating transaction counters, zeroed by soft clear.
   always_comb begin
      nb_reads_d  = nb_reads_q;
      nb_writes_d = nb_writes_q;
      if (clear_i) begin
         nb_reads_d  = '0;
         nb_writes_d = '0;
      end else begin
         if (rd_en && (nb_reads_q != 32'hFFFF_FFFF)) begin
            nb_reads_d = nb_reads_q + 32'd1;
         end
         if (wr_en && (nb_writes_q != 32'hFFFF_FFFF)) begin
            nb_writes_d = nb_writes_q + 32'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         nb_reads_q  <= '0;
         nb_writes_q <= '0;
      end else begin
         nb_reads_q  <= nb_reads_d;
         nb_writes_q <= nb_writes_d;
      end
   end

   assign nb_reads_o  = nb_reads_q;
   assign nb_writes_o = nb_writes_q;

endmodule

// File: tb/tb_hwpe_tcdm_responder.sv
// Directed bench: three responders (latency 1, 3, and 2 with a shifted base)
// share one stimulus stream; each is checked where its latency matters.
module tb_hwpe_tcdm_responder;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        stall;
   logic        req;
   logic [31:0] add;
   logic        wen;
   logic [3:0]  be;
   logic [31:0] wdata;

   logic [31:0] rd1, wr1, rd3, wr3, rd2, wr2;

   int n_checks = 0;
   int n_errors = 0;

   hwpe_tcdm_responder_if tcdm1 ();
   hwpe_tcdm_responder_if tcdm3 ();
   hwpe_tcdm_responder_if tcdm2 ();

   assign tcdm1.req = req;  assign tcdm1.add = add;  assign tcdm1.wen = wen;
   assign tcdm1.be  = be;   assign tcdm1.data = wdata;
   assign tcdm3.req = req;  assign tcdm3.add = add;  assign tcdm3.wen = wen;
   assign tcdm3.be  = be;   assign tcdm3.data = wdata;
   assign tcdm2.req = req;  assign tcdm2.add = add;  assign tcdm2.wen = wen;
   assign tcdm2.be  = be;   assign tcdm2.data = wdata;

   hwpe_tcdm_responder #(.MEM_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .stall_i(stall),
      .tcdm(tcdm1), .nb_reads_o(rd1), .nb_writes_o(wr1)
   );
   hwpe_tcdm_responder #(.MEM_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .stall_i(stall),
      .tcdm(tcdm3), .nb_reads_o(rd3), .nb_writes_o(wr3)
   );
   hwpe_tcdm_responder #(.MEM_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h1000)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .stall_i(stall),
      .tcdm(tcdm2), .nb_reads_o(rd2), .nb_writes_o(wr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
      req = r; wen = w; add = a; be = b; wdata = d;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; stall = 1'b0;
      drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rvalid1", tcdm1.r_valid, 1'b0);
      chk("rst_rdata1", tcdm1.r_data, 32'h0);
      chk("rst_rvalid3", tcdm3.r_valid, 1'b0);
      chk("rst_nbreads", rd1, 32'h0);
      chk("rst_nbwrites", wr1, 32'h0);
      chk("rst_gnt", tcdm1.gnt, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      next_cycle();

      // Two full writes then back-to-back reads (latency 1)
      drive(1'b1, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF);
      @(negedge clk); chk("wr0_gnt", tcdm1.gnt, 1'b1);
      next_cycle();
      drive(1'b1, 1'b0, 32'h4, 4'hF, 32'hCAFEF00D);
      next_cycle();
      drive(1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
      @(negedge clk); chk("no_rvalid_on_write", tcdm1.r_valid, 1'b0);
      next_cycle();
      drive(1'b1, 1'b1, 32'h4, 4'h0, 32'h0);
      @(negedge clk);
      chk("rd0_rvalid", tcdm1.r_valid, 1'b1);
      chk("rd0_rdata", tcdm1.r_data, 32'hDEADBEEF);
      next_cycle();
      drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("rd4_rvalid", tcdm1.r_valid, 1'b1);
      chk("rd4_rdata", tcdm1.r_data, 32'hCAFEF00D);
      chk("cnt_writes_2", wr1, 32'd2);
      chk("cnt_reads_2", rd1, 32'd2);
      next_cycle();
      @(negedge clk);
      chk("idle_rvalid", tcdm1.r_valid, 1'b0);
      chk("idle_rdata", tcdm1.r_data, 32'h0);
      repeat (3) next_cycle();

      // Byte-enable merge
      drive(1'b1, 1'b0, 32'h8, 4'hF, 32'h11223344);
      next_cycle();
      drive(1'b1, 1'b0, 32'h8, 4'b0101, 32'hAABBCCDD);
      next_cycle();
      drive(1'b1, 1'b1, 32'h8, 4'h0, 32'h0);
      next_cycle();
      drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("be_rvalid", tcdm1.r_valid, 1'b1);
      chk("be_merge", tcdm1.r_data, 32'h11BB33DD);
      repeat (4) next_cycle();

      // Latency 3: preload 8 words, then 8 consecutive reads
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 32'h40 + 32'(4 * i), 4'hF, 32'hA500_0000 + 32'(i));
         next_cycle();
      end
      for (int k = 0; k < 12; k++) begin
         if (k < 8) drive(1'b1, 1'b1, 32'h40 + 32'(4 * k), 4'h0, 32'h0);
         else drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
         @(negedge clk);
         if (k >= 3 && k <= 10) begin
            chk($sformatf("lat3_rvalid_%0d", k), tcdm3.r_valid, 1'b1);
            chk($sformatf("lat3_rdata_%0d", k), tcdm3.r_data, 32'hA500_0000 + 32'(k - 3));
         end else begin
            chk($sformatf("lat3_idle_%0d", k), tcdm3.r_valid, 1'b0);
         end
         next_cycle();
      end
      // Reads so far: 2 + 1 + 8 = 11; writes: 2 + 2 + 8 = 12
      chk("cnt_reads_11", rd3, 32'd11);
      chk("cnt_writes_12", wr3, 32'd12);
      repeat (2) next_cycle();

      // Stall holds off the grant for 5 cycles
      stall = 1'b1;
      drive(1'b1, 1'b1, 32'h8, 4'h0, 32'h0);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk($sformatf("stall_gnt_%0d", s), tcdm1.gnt, 1'b0);
         next_cycle();
      end
      chk("stall_cnt_held", rd1, 32'd11);
      stall = 1'b0;
      @(negedge clk); chk("release_gnt", tcdm1.gnt, 1'b1);
      next_cycle();
      drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("release_cnt", rd1, 32'd12);
      chk("release_rdata", tcdm1.r_data, 32'h11BB33DD);
      next_cycle();
      @(negedge clk); chk("release_single", rd1, 32'd12);
      repeat (4) next_cycle();

      // Address alias across the window (base 0x1000)
      drive(1'b1, 1'b0, 32'h1000, 4'hF, 32'h55);
      next_cycle();
      drive(1'b1, 1'b1, 32'h2000, 4'h0, 32'h0);
      next_cycle();
      drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
      @(negedge clk); chk("alias_not_yet", tcdm2.r_valid, 1'b0);
      next_cycle();
      @(negedge clk);
      chk("alias_rvalid", tcdm2.r_valid, 1'b1);
      chk("alias_rdata", tcdm2.r_data, 32'h55);
      repeat (4) next_cycle();

      // Clear in the cycle after a read grant (latency 2)
      drive(1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
      next_cycle();
      clear = 1'b1;
      @(negedge clk); chk("clear_gnt", tcdm2.gnt, 1'b0);
      next_cycle();
      clear = 1'b0;
      drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("clear_rvalid", tcdm2.r_valid, 1'b0);
      chk("clear_rdata", tcdm2.r_data, 32'h0);
      chk("clear_reads", rd2, 32'h0);
      chk("clear_writes", wr2, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("clear_rvalid_late", tcdm2.r_valid, 1'b0);
      chk("clear_rvalid_lat3", tcdm3.r_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
